// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID register; one outstanding imem request, 1-entry stall buffer.
// Optional FETCH_PERF_EN macro adds fetched/bubble performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_rdata_in,
  input  logic        imem_valid_in,
  output logic        valid_id_out,
  output logic [31:0] instr_id_out,
  output logic [31:0] pc_id_out,
  output logic [31:0] pc_plus4_id_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_out,
  output logic [31:0] perf_bubble_out
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        load_valid;
  logic [31:0] redirect;

  assign redirect = {redirect_pc_in[31:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pending_d   = pending_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    load_valid  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (flush_in) begin
          valid_d = 1'b0;
          instr_d = NOP;
          if (imem_valid_in) begin
            fetch_pc_d = redirect;
          end else begin
            pending_d = redirect;
            state_d   = S_DROP;
          end
        end else if (imem_valid_in) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (!stall_in) begin
            valid_d    = 1'b1;
            instr_d    = imem_rdata_in;
            pc_d       = fetch_pc_q;
            load_valid = 1'b1;
          end else begin
            buf_instr_d = imem_rdata_in;
            buf_pc_d    = fetch_pc_q;
            state_d     = S_HOLD;
          end
        end else if (!stall_in) begin
          valid_d = 1'b0;
          instr_d = NOP;
        end
      end
      S_HOLD: begin
        if (flush_in) begin
          valid_d    = 1'b0;
          instr_d    = NOP;
          fetch_pc_d = redirect;
          state_d    = S_FETCH;
        end else if (!stall_in) begin
          valid_d    = 1'b1;
          instr_d    = buf_instr_q;
          pc_d       = buf_pc_q;
          load_valid = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_DROP: begin
        // The stale response is swallowed; the newest redirect wins even if it lands with it.
        if (flush_in) pending_d = redirect;
        if (flush_in || !stall_in) begin
          valid_d = 1'b0;
          instr_d = NOP;
        end
        if (imem_valid_in) begin
          fetch_pc_d = flush_in ? redirect : pending_q;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_VECTOR;
      valid_q    <= 1'b0;
      instr_q    <= NOP;
      pc_q       <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    pending_q   <= pending_d;
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

  // Request is pure state; rst gating only keeps the bus quiet while reset is held.
  assign imem_req_out    = (state_q != S_HOLD) && !rst;
  assign imem_addr_out   = fetch_pc_q;
  assign valid_id_out    = valid_q;
  assign instr_id_out    = instr_q;
  assign pc_id_out       = pc_q;
  assign pc_plus4_id_out = pc_q + 32'd4;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= 32'd0;
      bubble_q  <= 32'd0;
    end else begin
      if (load_valid) fetched_q <= fetched_q + 32'd1;
      if (!valid_d)   bubble_q  <= bubble_q + 32'd1;
    end
  end

  assign perf_fetched_out = fetched_q;
  assign perf_bubble_out  = bubble_q;
`else
  logic unused_perf;
  assign unused_perf = load_valid;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF/ID entries, a negedge monitor pops them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_rdata_in;
  logic        imem_valid_in = 1'b0;
  logic        valid_id_out;
  logic [31:0] instr_id_out;
  logic [31:0] pc_id_out;
  logic [31:0] pc_plus4_id_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_out;
  logic [31:0] perf_bubble_out;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t exp_q[$];

  logic prev_load_ok = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .redirect_pc_in(redirect_pc_in), .imem_req_out(imem_req_out),
    .imem_addr_out(imem_addr_out), .imem_rdata_in(imem_rdata_in),
    .imem_valid_in(imem_valid_in), .valid_id_out(valid_id_out),
    .instr_id_out(instr_id_out), .pc_id_out(pc_id_out),
    .pc_plus4_id_out(pc_plus4_id_out)
`ifdef FETCH_PERF_EN
    , .perf_fetched_out(perf_fetched_out), .perf_bubble_out(perf_bubble_out)
`endif
  );

  // Instruction memory contents: a fixed tag xored with the word address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  assign imem_rdata_in = word_at(imem_addr_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = word_at(pc);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic s, input logic f, input logic [31:0] r);
    imem_valid_in  = v;
    stall_in       = s;
    flush_in       = f;
    redirect_pc_in = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // IF/ID only takes a new value on an edge with no reset, stall or flush.
  always @(posedge clk) prev_load_ok <= !rst && !stall_in && !flush_in;

  always @(negedge clk) begin
    if (!rst && prev_load_ok && valid_id_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_id_output", pc_id_out, 32'hXXXX_XXXX);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", pc_id_out, e.pc);
        chk("sb_instr", instr_id_out, e.instr);
        chk("sb_pc4", pc_plus4_id_out, e.pc + 32'd4);
      end
    end
  end

  initial begin
    @(negedge clk);
    step(0, 0, 0, 0);
    chk("rst_req", {31'd0, imem_req_out}, 32'd0);
    chk("rst_valid", {31'd0, valid_id_out}, 32'd0);
    chk("rst_instr", instr_id_out, 32'h0000_0013);
    chk("rst_pc", pc_id_out, 32'h100);
    chk("rst_pc4", pc_plus4_id_out, 32'h104);
    rst = 1'b0;
    #1;
    chk("first_req", {31'd0, imem_req_out}, 32'd1);
    chk("first_addr", imem_addr_out, 32'h100);

    // zero-wait fetch, then a 2-cycle stall while 0x104 returns
    push(32'h100); step(1, 0, 0, 0);
    chk("addr_104", imem_addr_out, 32'h104);
    chk("valid_c1", {31'd0, valid_id_out}, 32'd1);
    step(1, 1, 0, 0);
    chk("hold_req", {31'd0, imem_req_out}, 32'd0);
    chk("hold_pc", pc_id_out, 32'h100);
    step(0, 1, 0, 0);
    chk("hold_req2", {31'd0, imem_req_out}, 32'd0);
    chk("hold_pc2", pc_id_out, 32'h100);
    push(32'h104); step(0, 0, 0, 0);
    chk("release_addr", imem_addr_out, 32'h108);
    chk("release_req", {31'd0, imem_req_out}, 32'd1);

    // flush to 0x200 while 0x108 waits three cycles
    step(0, 0, 1, 32'h200);
    chk("drop_addr", imem_addr_out, 32'h108);
    chk("drop_valid", {31'd0, valid_id_out}, 32'd0);
    chk("drop_instr", instr_id_out, 32'h0000_0013);
    chk("drop_pc", pc_id_out, 32'h104);
    step(0, 0, 0, 0);
    chk("drop_addr2", imem_addr_out, 32'h108);
    step(1, 0, 0, 0);
    chk("redir_addr", imem_addr_out, 32'h200);
    chk("redir_valid", {31'd0, valid_id_out}, 32'd0);

    // flush and stall together
    push(32'h200); step(1, 0, 0, 0);
    step(1, 1, 1, 32'h40);
    chk("fs_valid", {31'd0, valid_id_out}, 32'd0);
    chk("fs_instr", instr_id_out, 32'h0000_0013);
    chk("fs_pc", pc_id_out, 32'h200);
    chk("fs_addr", imem_addr_out, 32'h40);

    // wrap at the top of the address space, then misaligned redirect
    step(1, 0, 1, 32'hFFFF_FFFC);
    chk("top_addr", imem_addr_out, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC); step(1, 0, 0, 0);
    chk("wrap_pc4", pc_plus4_id_out, 32'h0);
    chk("wrap_addr", imem_addr_out, 32'h0);
    step(1, 0, 1, 32'h203);
    chk("align_addr", imem_addr_out, 32'h200);

    // flush out of HOLD
    push(32'h200); step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("hold3_req", {31'd0, imem_req_out}, 32'd0);
    step(0, 0, 1, 32'h300);
    chk("hflush_addr", imem_addr_out, 32'h300);
    chk("hflush_req", {31'd0, imem_req_out}, 32'd1);
    chk("hflush_valid", {31'd0, valid_id_out}, 32'd0);
    push(32'h300); step(1, 0, 0, 0);
    push(32'h304); step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("bubble_valid", {31'd0, valid_id_out}, 32'd0);
    chk("bubble_pc", pc_id_out, 32'h304);

    // repeated flush while draining a stale response
    step(0, 0, 1, 32'h400);
    chk("drop2_addr", imem_addr_out, 32'h308);
    step(0, 0, 1, 32'h500);
    step(1, 0, 0, 0);
    chk("newest_redir", imem_addr_out, 32'h500);

    // reset mid-transfer, then 10 fetches around a 2-cycle stall
    rst = 1'b1;
    step(0, 0, 0, 0);
    chk("mid_rst_req", {31'd0, imem_req_out}, 32'd0);
    chk("mid_rst_pc", pc_id_out, 32'h100);
    rst = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("startup_addr", imem_addr_out, 32'h100);
    for (int i = 0; i < 5; i++) begin
      push(32'h100 + 32'(4 * i)); step(1, 0, 0, 0);
    end
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    push(32'h114); step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push(32'h118 + 32'(4 * i)); step(1, 0, 0, 0);
    end
    chk("final_addr", imem_addr_out, 32'h128);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched_out, 32'd10);
    chk("perf_bubble", perf_bubble_out, 32'd2);
`endif
    step(0, 0, 0, 0);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
